// File: rtl/grid_scheduler.sv
// rtl/grid_scheduler.sv - retry sequencer driving one sudoku grid generator through reset/settle/start/run
module grid_scheduler #(
    parameter int                    LFSR_WIDTH  = 8,
    parameter logic [LFSR_WIDTH-1:0] SEED_STRIDE = 8'h5B,
    parameter int                    RESET_CYC   = 2,
    parameter int                    READY_CYC   = 28,
    parameter int                    MAX_TRIES   = 4,
    parameter int                    TIMEOUT_W   = 16,
    localparam int                   TW          = $clog2(MAX_TRIES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LFSR_WIDTH-1:0] req_seed,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_success,
    output logic [TW-1:0]         res_tries,
    output logic                  res_timeout,
    output logic                  grid_reset,
    output logic                  grid_start,
    output logic [LFSR_WIDTH-1:0] grid_seed,
    input  logic                  grid_done,
    input  logic                  grid_success
);

    localparam int CNT_MAX = (READY_CYC > RESET_CYC) ? READY_CYC : RESET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_SETTLE, S_START, S_RUN, S_RETRY, S_REPORT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic [TIMEOUT_W-1:0]  wd_inc;
    logic [LFSR_WIDTH-1:0] seed_q, seed_d;
    logic [TW-1:0]         tries_q, tries_d;
    logic                  timeout_q, timeout_d;
    logic                  req_ready_q, req_ready_d;
    logic                  grid_reset_q, grid_reset_d;
    logic                  grid_start_q, grid_start_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_success_q, res_success_d;
    logic [TW-1:0]         res_tries_q, res_tries_d;
    logic                  res_timeout_q, res_timeout_d;

    // An all-zero seed would lock the grid LFSR, so it is promoted to 1.
    function automatic logic [LFSR_WIDTH-1:0] fix_seed(input logic [LFSR_WIDTH-1:0] x);
        return (x == '0) ? LFSR_WIDTH'(1) : x;
    endfunction

    assign wd_inc = wd_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wd_d          = wd_q;
        seed_d        = seed_q;
        tries_d       = tries_q;
        timeout_d     = timeout_q;
        grid_reset_d  = grid_reset_q;
        grid_start_d  = 1'b0;
        res_valid_d   = res_valid_q;
        res_success_d = res_success_q;
        res_tries_d   = res_tries_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            S_IDLE: begin
                grid_reset_d = 1'b1;
                if (req_valid) begin
                    seed_d    = fix_seed(req_seed);
                    tries_d   = TW'(1);
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RST;
                end
            end
            S_RST: begin
                if (cnt_q == CNT_W'(RESET_CYC - 1)) begin
                    cnt_d        = '0;
                    grid_reset_d = 1'b0;
                    state_d      = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(READY_CYC - 1)) begin
                    cnt_d        = '0;
                    grid_start_d = 1'b1;
                    state_d      = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_inc;
                // A done in the expiry cycle takes precedence over the watchdog.
                if (grid_done && grid_success) begin
                    grid_reset_d  = 1'b1;
                    res_valid_d   = 1'b1;
                    res_success_d = 1'b1;
                    res_tries_d   = tries_q;
                    res_timeout_d = 1'b0;
                    state_d       = S_REPORT;
                end else if (grid_done) begin
                    grid_reset_d = 1'b1;
                    timeout_d    = 1'b0;
                    state_d      = S_RETRY;
                end else if (wd_inc == {TIMEOUT_W{1'b1}}) begin
                    grid_reset_d = 1'b1;
                    timeout_d    = 1'b1;
                    state_d      = S_RETRY;
                end
            end
            S_RETRY: begin
                if (tries_q == TW'(MAX_TRIES)) begin
                    res_valid_d   = 1'b1;
                    res_success_d = 1'b0;
                    res_tries_d   = tries_q;
                    res_timeout_d = timeout_q;
                    state_d       = S_REPORT;
                end else begin
                    seed_d  = fix_seed(seed_q + SEED_STRIDE);
                    tries_d = tries_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_RST;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wd_q          <= '0;
            seed_q        <= '0;
            tries_q       <= '0;
            timeout_q     <= 1'b0;
            req_ready_q   <= 1'b1;
            grid_reset_q  <= 1'b1;
            grid_start_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_success_q <= 1'b0;
            res_tries_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wd_q          <= wd_d;
            seed_q        <= seed_d;
            tries_q       <= tries_d;
            timeout_q     <= timeout_d;
            req_ready_q   <= req_ready_d;
            grid_reset_q  <= grid_reset_d;
            grid_start_q  <= grid_start_d;
            res_valid_q   <= res_valid_d;
            res_success_q <= res_success_d;
            res_tries_q   <= res_tries_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign grid_reset  = grid_reset_q;
    assign grid_start  = grid_start_q;
    assign grid_seed   = seed_q;
    assign res_valid   = res_valid_q;
    assign res_success = res_success_q;
    assign res_tries   = res_tries_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_grid_scheduler.sv
// tb/tb_grid_scheduler.sv - scoreboard bench for grid_scheduler with a behavioural grid model
module tb_grid_scheduler;

    localparam int LW = 8;
    localparam int TW = 3;

    typedef struct packed {
        logic          s;
        logic [TW-1:0] t;
        logic          to;
    } res_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [LW-1:0] req_seed = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_success;
    logic [TW-1:0] res_tries;
    logic          res_timeout;
    logic          grid_reset;
    logic          grid_start;
    logic [LW-1:0] grid_seed;
    logic          grid_done;
    logic          grid_success;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int            plan[$];
    logic [LW-1:0] seed_exp[$];
    res_t          res_exp[$];

    grid_scheduler #(.TIMEOUT_W(6)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_seed(req_seed),
        .res_valid(res_valid), .res_ready(res_ready), .res_success(res_success),
        .res_tries(res_tries), .res_timeout(res_timeout),
        .grid_reset(grid_reset), .grid_start(grid_start), .grid_seed(grid_seed),
        .grid_done(grid_done), .grid_success(grid_success)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Grid model: plan entry >0 succeeds after N cycles, <0 fails after -N, 0 never finishes.
    initial begin
        grid_done = 1'b0;
        grid_success = 1'b0;
        forever begin
            @(negedge clock);
            if (grid_start === 1'b1) begin
                int p;
                int n;
                bit aborted;
                p = (plan.size() > 0) ? plan.pop_front() : 0;
                n = (p < 0) ? -p : p;
                aborted = 1'b0;
                if (p != 0) begin
                    for (int i = 1; i < n; i++) begin
                        @(negedge clock);
                        if (grid_reset === 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    if (!aborted) begin
                        grid_done = 1'b1;
                        grid_success = (p > 0);
                    end
                end
                for (int i = 0; i < 2000 && grid_reset !== 1'b1; i++) @(negedge clock);
                repeat (2) @(negedge clock);
                grid_done = 1'b0;
                grid_success = 1'b0;
            end
        end
    end

    function automatic logic [LW-1:0] fixs(input logic [LW-1:0] x);
        return (x == '0) ? 8'h01 : x;
    endfunction

    task automatic send_req(input logic [LW-1:0] s, output int acc, output bit ok);
        ok = 1'b0;
        acc = 0;
        req_seed = s;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready === 1'b1) begin
                acc = cyc + 1;
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_start(output int sc, output bit ok, output bit saw_rst);
        ok = 1'b0;
        sc = 0;
        saw_rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (grid_reset === 1'b1) saw_rst = 1'b1;
            if (grid_start === 1'b1) begin
                sc = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_result(output bit ok, output bit extra);
        ok = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            if (grid_start === 1'b1) extra = 1'b1;
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({grid_reset, grid_start, grid_seed, req_ready} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_ctrl got rst=%b start=%b seed=%h rdy=%b want 1 0 00 1",
                     grid_reset, grid_start, grid_seed, req_ready);
        end
        n_checks++;
        if ({res_valid, res_success, res_tries, res_timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_res got v=%b s=%b t=%0d to=%b want all 0",
                     res_valid, res_success, res_tries, res_timeout);
        end
    endtask

    task automatic test_single_success();
        int acc, sc;
        bit ok, saw, extra;
        res_t r;
        logic [LW-1:0] e;
        plan.push_back(50);
        seed_exp.push_back(fixs(8'h3C));
        res_exp.push_back('{s: 1'b1, t: 3'd1, to: 1'b0});
        send_req(8'h3C, acc, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_accept got no accept want accept"); end
        wait_start(sc, ok, saw);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_start got no start want start");
        end else begin
            e = seed_exp.pop_front();
            if (grid_seed !== e) begin n_fail++; $display("FAIL single_seed got %h want %h", grid_seed, e); end
            n_checks++;
            if (sc + 1 - acc !== 31) begin n_fail++; $display("FAIL single_latency got %0d want 31", sc + 1 - acc); end
        end
        wait_result(ok, extra);
        r = res_exp.pop_front();
        n_checks++;
        if (!ok || {res_success, res_tries, res_timeout} !== r) begin
            n_fail++;
            $display("FAIL single_result got v=%b %b/%0d/%b want 1 %b/%0d/%b",
                     res_valid, res_success, res_tries, res_timeout, r.s, r.t, r.to);
        end
        take_result();
    endtask

    task automatic test_retry();
        int acc, sc;
        bit ok, saw, extra;
        res_t r;
        logic [LW-1:0] s, e;
        plan.push_back(-20); plan.push_back(-20); plan.push_back(50);
        s = 8'h3C;
        for (int a = 0; a < 3; a++) begin
            seed_exp.push_back(fixs(s));
            s = fixs(s) + 8'h5B;
        end
        res_exp.push_back('{s: 1'b1, t: 3'd3, to: 1'b0});
        send_req(8'h3C, acc, ok);
        for (int a = 0; a < 3; a++) begin
            wait_start(sc, ok, saw);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL retry_start%0d got no start want start", a);
            end else begin
                e = seed_exp.pop_front();
                if (grid_seed !== e) begin n_fail++; $display("FAIL retry_seed%0d got %h want %h", a, grid_seed, e); end
            end
            if (a > 0) begin
                n_checks++;
                if (saw !== 1'b1) begin n_fail++; $display("FAIL retry_gridreset%0d got 0 want 1", a); end
            end
        end
        wait_result(ok, extra);
        r = res_exp.pop_front();
        n_checks++;
        if (!ok || {res_success, res_tries, res_timeout} !== r) begin
            n_fail++;
            $display("FAIL retry_result got %b/%0d/%b want %b/%0d/%b",
                     res_success, res_tries, res_timeout, r.s, r.t, r.to);
        end
        take_result();
    endtask

    task automatic test_exhaust();
        int acc, sc, starts;
        bit ok, saw, extra;
        res_t r;
        logic [LW-1:0] s, e;
        s = 8'h10;
        for (int a = 0; a < 4; a++) begin
            plan.push_back(-10);
            seed_exp.push_back(fixs(s));
            s = fixs(s) + 8'h5B;
        end
        res_exp.push_back('{s: 1'b0, t: 3'd4, to: 1'b0});
        starts = 0;
        send_req(8'h10, acc, ok);
        for (int a = 0; a < 4; a++) begin
            wait_start(sc, ok, saw);
            if (ok) begin
                starts++;
                e = seed_exp.pop_front();
                n_checks++;
                if (grid_seed !== e) begin n_fail++; $display("FAIL exhaust_seed%0d got %h want %h", a, grid_seed, e); end
            end
        end
        wait_result(ok, extra);
        if (extra) starts++;
        n_checks++;
        if (starts !== 4) begin n_fail++; $display("FAIL exhaust_starts got %0d want 4", starts); end
        r = res_exp.pop_front();
        n_checks++;
        if (!ok || {res_success, res_tries, res_timeout} !== r) begin
            n_fail++;
            $display("FAIL exhaust_result got %b/%0d/%b want %b/%0d/%b",
                     res_success, res_tries, res_timeout, r.s, r.t, r.to);
        end
        take_result();
    endtask

    task automatic test_timeout();
        int acc, sc, n;
        bit ok, saw, extra;
        res_t r;
        for (int a = 0; a < 4; a++) plan.push_back(0);
        res_exp.push_back('{s: 1'b0, t: 3'd4, to: 1'b1});
        send_req(8'h80, acc, ok);
        for (int a = 0; a < 4; a++) begin
            wait_start(sc, ok, saw);
            n = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clock);
                if (grid_reset === 1'b1) break;
                n++;
            end
            n_checks++;
            if (!ok || n !== 63) begin n_fail++; $display("FAIL timeout_run%0d got %0d cycles want 63", a, n); end
        end
        wait_result(ok, extra);
        r = res_exp.pop_front();
        n_checks++;
        if (!ok || {res_success, res_tries, res_timeout} !== r) begin
            n_fail++;
            $display("FAIL timeout_result got %b/%0d/%b want %b/%0d/%b",
                     res_success, res_tries, res_timeout, r.s, r.t, r.to);
        end
        take_result();
    endtask

    task automatic test_zero_seed();
        int acc, sc;
        bit ok, saw, extra;
        res_t r;
        logic [LW-1:0] e;
        plan.push_back(30);
        seed_exp.push_back(fixs(8'h00));
        send_req(8'h00, acc, ok);
        wait_start(sc, ok, saw);
        e = seed_exp.pop_front();
        n_checks++;
        if (!ok || grid_seed !== e) begin n_fail++; $display("FAIL zero_seed got %h want %h", grid_seed, e); end
        wait_result(ok, extra);
        take_result();
        plan.push_back(-20); plan.push_back(30);
        seed_exp.push_back(fixs(8'hA5));
        seed_exp.push_back(fixs(8'hA5 + 8'h5B));
        res_exp.push_back('{s: 1'b1, t: 3'd2, to: 1'b0});
        send_req(8'hA5, acc, ok);
        for (int a = 0; a < 2; a++) begin
            wait_start(sc, ok, saw);
            e = seed_exp.pop_front();
            n_checks++;
            if (!ok || grid_seed !== e) begin n_fail++; $display("FAIL wrap_seed%0d got %h want %h", a, grid_seed, e); end
        end
        wait_result(ok, extra);
        r = res_exp.pop_front();
        n_checks++;
        if (!ok || {res_success, res_tries, res_timeout} !== r) begin
            n_fail++;
            $display("FAIL wrap_result got %b/%0d/%b want %b/%0d/%b",
                     res_success, res_tries, res_timeout, r.s, r.t, r.to);
        end
        take_result();
    endtask

    task automatic test_hold_and_abort();
        int acc, sc, bad;
        bit ok, saw, extra;
        res_t r;
        plan.push_back(40);
        seed_exp.push_back(fixs(8'h5A));
        res_exp.push_back('{s: 1'b1, t: 3'd1, to: 1'b0});
        send_req(8'h5A, acc, ok);
        wait_start(sc, ok, saw);
        void'(seed_exp.pop_front());
        wait_result(ok, extra);
        r = res_exp[0];
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i % 3 == 1);
            req_seed = 8'hEE;
            @(negedge clock);
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || grid_start !== 1'b0 ||
                {res_success, res_tries, res_timeout} !== r) bad++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        void'(res_exp.pop_front());
        take_result();
        n_checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release got v=%b rdy=%b want 0 1", res_valid, req_ready);
        end
        plan.push_back(0);
        seed_exp.push_back(fixs(8'h11));
        send_req(8'h11, acc, ok);
        wait_start(sc, ok, saw);
        void'(seed_exp.pop_front());
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (grid_reset !== 1'b1 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset got rst=%b rdy=%b v=%b want 1 1 0", grid_reset, req_ready, res_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (res_valid !== 1'b0 || grid_start !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL abort_noresult got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b1;
        @(negedge clock);
        test_single_success();
        test_retry();
        test_exhaust();
        test_timeout();
        test_zero_seed();
        test_hold_and_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no completion want completion");
        $fatal(1, "bench time limit");
    end

endmodule
